// File: rtl/jk_pkg.sv
// Shared JK command encoding and the single-cell next-state rule used by the bank.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  // Next value of one JK cell given its present value and the command.
  function automatic logic jk_next(input logic q, input jk_cmd_e jk);
    logic n;
    case (jk)
      JK_HOLD:   n = q;
      JK_RESET:  n = 1'b0;
      JK_SET:    n = 1'b1;
      JK_TOGGLE: n = ~q;
      default:   n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grant the first requester at or after the priority pointer,
// and move the pointer just past the winner whenever a grant is consumed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_s;
  logic          found_s;

  // Cyclic priority search starting at ptr_q; purely combinational on req.
  always_comb begin
    int c;
    gnt     = '0;
    win_s   = '0;
    found_s = 1'b0;
    c       = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr_q) + i;
      if (c >= N) begin
        c = c - N;
      end else begin
        c = c;
      end
      if (!found_s && req[c]) begin
        found_s = 1'b1;
        gnt[c]  = 1'b1;
        win_s   = PW'(c);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer update: wraps from N-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found_s) begin
      if (int'(win_s) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_s + PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Arbitrated single write port for a bank of JK cells: round-robin grant, capture
// stage (qm) then apply stage updating the architectural bank qs one bit per cycle.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int GIDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ*2-1:0]    req_jk,
  output logic [2+IDXW-1:0]    qm,
  output logic                 qm_valid,
  output logic [WIDTH-1:0]     qs,
  output logic                 done,
  output logic [GIDW-1:0]      grant_id
);

  logic [NREQ-1:0] gnt_s;
  logic            transfer_s;
  logic [GIDW-1:0] win_id_s;
  logic [1:0]      win_jk_s;
  logic [IDXW-1:0] win_idx_s;

  logic [2+IDXW-1:0] qm_q, qm_d;
  logic              qm_valid_q, qm_valid_d;
  logic [GIDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  qs_q, qs_d;
  logic              done_q, done_d;
  logic [GIDW-1:0]   grant_id_q, grant_id_d;

  logic [1:0]        qm_jk_s;
  logic [IDXW-1:0]   qm_idx_s;

  // Grants follow req_valid even while rst is high; only the capture is suppressed.
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (transfer_s),
    .gnt     (gnt_s)
  );

  assign req_ready  = gnt_s;
  assign transfer_s = |(req_valid & gnt_s);

  // Mux the granted requester's id and payload out of the packed buses.
  always_comb begin
    win_id_s  = '0;
    win_jk_s  = 2'b00;
    win_idx_s = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_s[r]) begin
        win_id_s  = GIDW'(r);
        win_jk_s  = req_jk[r*2 +: 2];
        win_idx_s = req_idx[r*IDXW +: IDXW];
      end else begin
        win_id_s = win_id_s;
      end
    end
  end

  assign qm_jk_s  = qm_q[2+IDXW-1 -: 2];
  assign qm_idx_s = qm_q[IDXW-1:0];

  // Capture stage next state: qm keeps its last contents when idle.
  always_comb begin
    qm_d       = qm_q;
    id_d       = id_q;
    qm_valid_d = transfer_s;
    if (transfer_s) begin
      qm_d = {win_jk_s, win_idx_s};
      id_d = win_id_s;
    end else begin
      qm_d = qm_q;
      id_d = id_q;
    end
  end

  // Apply stage next state: evaluated against the current bank, so same-bit
  // back-to-back commands chain naturally.
  always_comb begin
    qs_d       = qs_q;
    done_d     = qm_valid_q;
    grant_id_d = grant_id_q;
    if (qm_valid_q) begin
      qs_d[qm_idx_s] = jk_next(qs_q[qm_idx_s], jk_cmd_e'(qm_jk_s));
      grant_id_d     = id_q;
    end else begin
      grant_id_d = grant_id_q;
    end
  end

  // Pipeline and bank registers; reset discards any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm_q       <= '0;
      qm_valid_q <= 1'b0;
      id_q       <= '0;
      qs_q       <= '0;
      done_q     <= 1'b0;
      grant_id_q <= '0;
    end else begin
      qm_q       <= qm_d;
      qm_valid_q <= qm_valid_d;
      id_q       <= id_d;
      qs_q       <= qs_d;
      done_q     <= done_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign qm       = qm_q;
  assign qm_valid = qm_valid_q;
  assign qs       = qs_q;
  assign done     = done_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Randomized bench for jk_bank_arbiter with a queue-based reference model.
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 3;
  localparam int GIDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ*2-1:0]    req_jk;
  logic [2+IDXW-1:0]    qm;
  logic                 qm_valid;
  logic [WIDTH-1:0]     qs;
  logic                 done;
  logic [GIDW-1:0]      grant_id;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_jk(req_jk), .qm(qm), .qm_valid(qm_valid),
    .qs(qs), .done(done), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Requester-side pending commands (held stable until granted).
  bit         pv   [NREQ];
  logic [2:0] pidx [NREQ];
  logic [1:0] pjk  [NREQ];

  // Reference model state.
  typedef struct { int jk; int idx; int id; int born; } cmd_t;
  cmd_t             pipe[$];
  logic [WIDTH-1:0] m_qs;
  int               m_ptr, m_gid, edge_no;
  bit               m_done, m_qmv;
  logic [4:0]       m_qm;

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      req_valid[r]              = pv[r];
      req_idx[r*IDXW +: IDXW]   = pidx[r];
      req_jk[r*2 +: 2]          = pjk[r];
    end
  endtask

  function automatic int exp_grant();
    for (int i = 0; i < NREQ; i++) begin
      if (pv[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pipe.delete();
    m_qs = '0; m_ptr = 0; m_gid = 0; m_done = 0; m_qmv = 0; m_qm = '0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  // g returns the requester that completed a transfer, or -1.
  task automatic step(output int g);
    cmd_t c;
    bit   b, applied;
    @(negedge clk);
    check_eq("qs", qs, m_qs);
    check_eq("done", done, m_done);
    check_eq("grant_id", grant_id, m_gid);
    check_eq("qm_valid", qm_valid, m_qmv);
    check_eq("qm", qm, m_qm);
    g = exp_grant();
    check_eq("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    edge_no++;
    if (!rst) begin
      applied = 0;
      while (pipe.size() > 0 && pipe[0].born < edge_no) begin
        c = pipe.pop_front();
        b = m_qs[c.idx];
        case (c.jk)
          1: b = 1'b0;
          2: b = 1'b1;
          3: b = ~b;
          default: b = b;
        endcase
        m_qs[c.idx] = b;
        m_gid = c.id;
        applied = 1;
      end
      m_done = applied;
      if (g >= 0) begin
        pipe.push_back('{jk: int'(pjk[g]), idx: int'(pidx[g]), id: g, born: edge_no});
        m_qmv = 1;
        m_qm  = {pjk[g], pidx[g]};
        m_ptr = (g + 1) % NREQ;
      end else begin
        m_qmv = 0;
      end
    end else begin
      g = -1;
    end
    #1;
  endtask

  // Asynchronous reset assertion between edges; outputs must clear at once.
  task automatic inject_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_qs", qs, 0);
    check_eq("rst_qm", qm, 0);
    check_eq("rst_qm_valid", qm_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_grant_id", grant_id, 0);
    model_reset();
  endtask

  int g;
  int order[$];

  initial begin
    edge_no = 0;
    for (int r = 0; r < NREQ; r++) begin pv[r] = 0; pidx[r] = '0; pjk[r] = '0; end
    drive();
    rst = 1'b1;
    model_reset();
    #12;
    check_eq("init_qs", qs, 0);
    check_eq("init_ready", req_ready, 0);
    check_eq("init_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single requester: r0 SET idx 5.
    pv[0] = 1; pidx[0] = 3'd5; pjk[0] = 2'b10; drive();
    step(g);
    pv[0] = 0; drive();
    step(g);
    check_eq("single_qs", qs, 8'h20);
    check_eq("single_done", done, 1);
    check_eq("single_gid", grant_id, 0);
    step(g);
    step(g);

    // Captured SET idx 3 is discarded by reset before it is applied.
    inject_reset();
    rst = 1'b0;
    pv[0] = 1; pidx[0] = 3'd3; pjk[0] = 2'b10; drive();
    step(g);
    pv[0] = 0; drive();
    inject_reset();
    step(g);
    step(g);
    rst = 1'b0;
    step(g);
    check_eq("discard_qs", qs, 8'h00);

    // Contention: all four toggle their own bit, ptr at 0.
    for (int r = 0; r < NREQ; r++) begin pv[r] = 1; pidx[r] = 3'(r); pjk[r] = 2'b11; end
    drive();
    for (int i = 0; i < NREQ; i++) begin
      step(g);
      check_eq("contention_order", g, i);
      if (g >= 0) pv[g] = 0;
      drive();
    end
    step(g);
    step(g);
    check_eq("contention_qs", qs, 8'h0F);

    // Random traffic with a mid-stream reset.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) inject_reset();
      if (cyc == 203) rst = 1'b0;
      step(g);
      if (g >= 0) begin
        pv[g]   = ($urandom_range(0, 3) != 0);
        pidx[g] = 3'($urandom_range(0, WIDTH - 1));
        pjk[g]  = 2'($urandom_range(0, 3));
      end
      for (int r = 0; r < NREQ; r++) begin
        if (!pv[r] && r != g && $urandom_range(0, 1) == 1) begin
          pv[r]   = 1;
          pidx[r] = 3'($urandom_range(0, WIDTH - 1));
          pjk[r]  = 2'($urandom_range(0, 3));
        end
      end
      drive();
    end
    for (int r = 0; r < NREQ; r++) pv[r] = 0;
    drive();
    for (int i = 0; i < 4; i++) step(g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin arbiter and sequencer that shares a WIDTH-bit bank of JK storage cells among NREQ requesters. Each requester issues single-bit JK commands (hold/reset/set/toggle) through a valid/ready handshake. Accepted commands pass through a two-stage master/slave path, capture then apply, so bank updates are strictly ordered and one per cycle. The block sits above the JK flip-flop primitives as their only write port and exposes the whole bank to downstream logic.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of JK cells in the bank (power of 2, 2..64)
- IDXW, $clog2(WIDTH), derived, bit-index width (not overridden)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester grant, one-hot or zero, combinational
- req_idx  in  NREQ*IDXW  target bit; requester r occupies slice [r*IDXW +: IDXW]
- req_jk  in  NREQ*2  command {j,k}; requester r occupies slice [r*2 +: 2]
- qm  out  2+IDXW  master-stage contents {jk, idx}, for debug
- qm_valid  out  1  master stage holds a pending command
- qs  out  WIDTH  slave bank, the architectural JK state
- done  out  1  one-cycle pulse: a command was applied to qs on this edge
- grant_id  out  $clog2(NREQ)  index of the requester whose command was applied last

## Operation
- Encoding of {j,k}: 00 hold, 01 reset bit to 0, 10 set bit to 1, 11 toggle bit.
- Arbitration:
  - Round-robin over req_valid, starting at priority pointer ptr.
  - Exactly one req_ready is high when any req_valid is high, else none.
  - req_ready never depends on req_ready (no loop).
  - The stage is always able to accept, so there is no back-pressure beyond arbitration.
- Handshake: a transfer occurs when req_valid[r] & req_ready[r]. Non-granted requesters keep valid and payload stable until granted.
- On a transfer, ptr moves to (r+1) mod NREQ. Without a transfer, ptr holds.
- Capture stage:
  - Edge after a transfer: qm <= {jk, idx} of the winner, qm_valid <= 1, and the winner's id is stored.
  - Edge with no transfer: qm_valid <= 0.
- Apply stage: on each edge with qm_valid=1:
  - Update qs[idx] per jk, evaluated against the current qs. Hold (00) still counts as applied.
  - done <= 1 and grant_id <= stored id.
  - All other qs bits are unchanged.
- Back-to-back commands on the same bit are evaluated in order. Each sees the result of the previous one, so there is no hazard.
- Idle state: stages drain, qs holds.
- Reset (async, immediate):
  - qs=0, qm=0, qm_valid=0, done=0, grant_id=0, ptr=0.
  - An in-flight command is discarded.
  - req_ready is combinational and follows req_valid even while rst is high. Transfers during rst are ignored: no capture, ptr is not advanced.

## Timing
- Latency: transfer in cycle T, capture at edge T+1, qs updated and done high after edge T+2 (2-cycle latency).
- Throughput: one command per cycle sustained.
- Simultaneous requests: serviced in round-robin order starting from ptr. No requester waits more than NREQ-1 transfers.
- Index out of range is impossible because WIDTH is a power of 2.
- Deassertion of rst: the first transfer is possible in the same cycle. The first capture happens on the first edge after rst falls.

## Structure
- Shared package jk_pkg:
  - jk_cmd_e enum {JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11}.
  - Function jk_next(q, jk) returning the next bit value.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs clk, rst, req[N], advance.
  - Output gnt[N] one-hot, plus an internal ptr.
- Top level holds the capture register, the apply logic and the qs bank.

## Test plan
- Reset: drive stimulus, assert rst mid-stream → all outputs 0 immediately. A pending capture of SET idx 3 never reaches qs.
- Single requester: r0 SET idx 5 in cycle T → qs=8'h20 after edge T+2, done pulses once, grant_id=0.
- Command coverage on idx 2 from r1: SET, TOGGLE, TOGGLE, RESET, HOLD back-to-back → qs[2] reads 1, 0, 1, 0, 0 on consecutive edges. done stays high for 5 cycles.
- Contention: all 4 valid with ptr=0, each TOGGLE on own idx 0..3 → grant order 0,1,2,3. qs=8'h0F after 6 cycles. Each requester is ready exactly once.
- Fairness: r0 and r2 held valid continuously with 10 transfers → alternating grants 0,2,0,2…, 5 each, no starvation.
- Same-bit conflict: r0 SET idx 7 and r3 RESET idx 7 valid together with ptr=0 → r0 applied first, then r3. Final qs[7]=0, grant_id sequence 0 then 3.
